// File: rtl/fetch_queue_if.sv
// Fetch/decode side signals of the instruction fetch queue.
// The stall_cycles statistic exists only when FETCH_QUEUE_STATS_EN is defined.
interface fetch_queue_if #(
  parameter int PUSH_WIDTH = 4,
  parameter int POP_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
);
  // Push: a bundle transfers on a rising edge when push_valid && push_ready;
  // push_ready depends only on queue state. Pop: decode presents pop_take
  // (0..pop_count) and those oldest entries leave on the same edge.
  logic                             flush;
  logic                             push_valid;
  logic [2:0]                       push_count;
  logic [DATA_WIDTH-1:0]            push_pc;
  logic [PUSH_WIDTH*DATA_WIDTH-1:0] push_inst;
  logic                             push_ready;
  logic [2:0]                       pop_count;
  logic [POP_WIDTH*DATA_WIDTH-1:0]  pop_inst;
  logic [POP_WIDTH*DATA_WIDTH-1:0]  pop_pc;
  logic [2:0]                       pop_take;
  logic                             empty;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0]                      stall_cycles;
`endif

  modport master (
    output flush,
    output push_valid,
    output push_count,
    output push_pc,
    output push_inst,
    output pop_take,
    input  push_ready,
    input  pop_count,
    input  pop_inst,
    input  pop_pc,
    input  empty
`ifdef FETCH_QUEUE_STATS_EN
    , input stall_cycles
`endif
  );

  modport slave (
    input  flush,
    input  push_valid,
    input  push_count,
    input  push_pc,
    input  push_inst,
    input  pop_take,
    output push_ready,
    output pop_count,
    output pop_inst,
    output pop_pc,
    output empty
`ifdef FETCH_QUEUE_STATS_EN
    , output stall_cycles
`endif
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode with bundle push and prefix pop.
// Define FETCH_QUEUE_STATS_EN to add the saturating stall_cycles counter.
module fetch_queue #(
  parameter int DEPTH      = 16,
  parameter int PUSH_WIDTH = 4,
  parameter int POP_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  fetch_queue_if.slave fq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem_inst [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_pc   [DEPTH];
  logic [AW-1:0]         r_head;
  logic [AW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  logic                             w_push_ready;
  logic [2:0]                       w_push_n;
  logic [2:0]                       w_avail;
  logic [2:0]                       w_take;
  logic [POP_WIDTH*DATA_WIDTH-1:0]  w_pop_inst;
  logic [POP_WIDTH*DATA_WIDTH-1:0]  w_pop_pc;

  // Ready needs room for a whole bundle, whatever decode takes this cycle.
  assign w_push_ready = (r_count <= CW'(DEPTH - PUSH_WIDTH));
  assign w_avail      = (r_count >= CW'(POP_WIDTH)) ? 3'(POP_WIDTH) : r_count[2:0];

  always_comb begin
    w_push_n = '0;
    if (fq.push_valid && w_push_ready && !fq.flush) begin
      w_push_n = (fq.push_count > 3'(PUSH_WIDTH)) ? 3'(PUSH_WIDTH) : fq.push_count;
    end
  end

  always_comb begin
    w_take = '0;
    if (!fq.flush) begin
      w_take = (fq.pop_take > w_avail) ? w_avail : fq.pop_take;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (fq.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_take);
      r_tail  <= r_tail + AW'(w_push_n);
      r_count <= r_count + CW'(w_push_n) - CW'(w_take);
    end
  end

  // Entry storage needs no reset: slots beyond pop_count are masked to zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_WIDTH; i++) begin
      if (i < int'(w_push_n)) begin
        r_mem_inst[r_tail + AW'(i)] <= fq.push_inst[i*DATA_WIDTH +: DATA_WIDTH];
        r_mem_pc[r_tail + AW'(i)]   <= fq.push_pc + DATA_WIDTH'(4 * i);
      end
    end
  end

  always_comb begin
    w_pop_inst = '0;
    w_pop_pc   = '0;
    for (int i = 0; i < POP_WIDTH; i++) begin
      if (i < int'(w_avail)) begin
        w_pop_inst[i*DATA_WIDTH +: DATA_WIDTH] = r_mem_inst[r_head + AW'(i)];
        w_pop_pc[i*DATA_WIDTH +: DATA_WIDTH]   = r_mem_pc[r_head + AW'(i)];
      end
    end
  end

  assign fq.push_ready = w_push_ready;
  assign fq.pop_count  = w_avail;
  assign fq.pop_inst   = w_pop_inst;
  assign fq.pop_pc     = w_pop_pc;
  assign fq.empty      = (r_count == '0);

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] r_stall_cycles;

  // Counts fetch-side back-pressure; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (fq.push_valid && !w_push_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign fq.stall_cycles = r_stall_cycles;
`else
  // Without statistics nothing observes the fetch-side stall condition.
`endif

  a_pop_take_legal: assert property (@(posedge clk) disable iff (!rst_n)
    fq.pop_take <= w_avail);

  a_push_count_legal: assert property (@(posedge clk) disable iff (!rst_n)
    fq.push_valid |-> (fq.push_count <= 3'(PUSH_WIDTH)));
endmodule
